// File: rtl/ucc_pkg.sv
// Shared encodings for the UCC monitor blocks: execution-state values,
// single-operand instruction codes and the shadow-return checker FSM states.
package ucc_pkg;

  localparam logic [3:0] CALL_STATE = 4'hB;
  localparam logic [3:0] IRQ_STATE  = 4'h1;
  localparam logic [3:0] RET_STATE  = 4'hC;

  localparam logic [7:0] CALL_INST  = 8'h20;
  localparam logic [7:0] IRQ_INST   = 8'h80;
  localparam logic [7:0] RETI_INST  = 8'h40;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } chk_state_e;

endpackage

// File: rtl/shadow_lifo_mem.sv
// Shadow-stack storage: DEPTH x 16 register file with one synchronous write
// port and one combinational read port. Contents are not reset.
module shadow_lifo_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [15:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/shadow_return_checker.sv
// Shadow return-address checker: pushes return addresses on CALL/IRQ entry,
// pops them on RET/RETI and flags the core resuming anywhere else.
module shadow_return_checker
  import ucc_pkg::*;
#(
  parameter int         DEPTH     = 8,
  parameter int         PTR_W     = 3,
  parameter logic [3:0] POP_STATE = RET_STATE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       inst_so,
  input  logic [3:0]       e_state,
  input  logic [15:0]      mdb_out,
  input  logic             ret_inst,
  input  logic [15:0]      pc,
  output logic [PTR_W:0]   depth,
  output logic [15:0]      exp_addr,
  output logic             viol_mismatch,
  output logic             viol_overflow,
  output logic             viol_underflow,
  output logic             violation
);

  localparam logic [PTR_W:0]   DEPTH_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] IDX_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};

  chk_state_e     state_q;
  logic [PTR_W:0] depth_q, depth_d;
  logic [15:0]    exp_addr_q, pc_pop_q;
  logic           mismatch_q, overflow_q, underflow_q;

  logic             push_s, pop_s, pop_ok_s, empty_s, full_s, compare_s;
  logic             we_s;
  logic [PTR_W-1:0] top_idx_s, waddr_s;
  logic [15:0]      rdata_s;

  assign push_s   = ((e_state == CALL_STATE) && (inst_so == CALL_INST)) ||
                    ((e_state == IRQ_STATE)  && (inst_so == IRQ_INST));
  assign pop_s    = (e_state == POP_STATE) && (ret_inst || (inst_so == RETI_INST));
  assign empty_s  = (depth_q == {(PTR_W+1){1'b0}});
  assign full_s   = (depth_q == DEPTH_FULL);
  assign pop_ok_s = pop_s && !empty_s;

  // Low bits wrap to DEPTH-1 when full, which is the top entry.
  assign top_idx_s = depth_q[PTR_W-1:0] - IDX_ONE;

  // A pop is resolved first, so a same-cycle push overwrites the popped slot.
  assign we_s    = push_s && (pop_ok_s || !full_s);
  assign waddr_s = pop_ok_s ? top_idx_s : depth_q[PTR_W-1:0];

  assign compare_s = (state_q == CHECK) && (pop_s || (pc != pc_pop_q));

  // Net occupancy change after resolving the pop and the push.
  always_comb begin
    depth_d = depth_q;
    if (pop_ok_s && !we_s) begin
      depth_d = depth_q - {{PTR_W{1'b0}}, 1'b1};
    end else if (!pop_ok_s && we_s) begin
      depth_d = depth_q + {{PTR_W{1'b0}}, 1'b1};
    end else begin
      depth_d = depth_q;
    end
  end

  shadow_lifo_mem #(
    .DEPTH (DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (we_s),
    .waddr_i (waddr_s),
    .wdata_i (mdb_out),
    .raddr_i (top_idx_s),
    .rdata_o (rdata_s)
  );

  // Checker FSM, stack pointer and sticky violation flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      depth_q     <= {(PTR_W+1){1'b0}};
      exp_addr_q  <= 16'h0000;
      pc_pop_q    <= 16'h0000;
      mismatch_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      depth_q <= depth_d;
      if (push_s && !pop_ok_s && full_s) begin
        overflow_q <= 1'b1;
      end
      if (pop_s && empty_s) begin
        underflow_q <= 1'b1;
      end
      if (compare_s && (pc != exp_addr_q)) begin
        mismatch_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (pop_ok_s) begin
            exp_addr_q <= rdata_s;
            pc_pop_q   <= pc;
            state_q    <= CHECK;
          end
        end
        CHECK: begin
          if (pop_ok_s) begin
            exp_addr_q <= rdata_s;
            pc_pop_q   <= pc;
            state_q    <= CHECK;
          end else if (compare_s) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign depth          = depth_q;
  assign exp_addr       = exp_addr_q;
  assign viol_mismatch  = mismatch_q;
  assign viol_overflow  = overflow_q;
  assign viol_underflow = underflow_q;
  assign violation      = mismatch_q | overflow_q | underflow_q;

endmodule
